siic_master: RTL

Register-driven I2C master that performs single-byte write and read transactions to the image sensor's configuration port over the open-drain SIIC pads. Sits in the MCK domain beside the host-side I2C slave. Its command fields are fed from main-top register bits, and its status and read data are returned through the read-register mux. Register addresses of 8 or 16 bits are supported, with slave clock stretching and slave-NACK abort.

---
 rtl/siic_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/siic_master.sv
// Register-driven single-byte I2C master for the sensor configuration port.
// Write/read with 8- or 16-bit register address, clock stretching and NACK abort.
module siic_master #(
    parameter int CLK_DIV = 125
) (
    input  logic        MCK,
    input  logic        RST,
    input  logic        START,
    input  logic [6:0]  SLAVE,
    input  logic        RW,
    input  logic        ADDR16,
    input  logic [15:0] REG_ADDR,
    input  logic [7:0]  WDAT,
    output logic        BUSY,
    output logic        DONE,
    output logic        NACK,
    output logic [7:0]  RDAT,
    output logic        dSIIC_SCL,
    output logic        dSIIC_SDA,
    input  logic        iSIIC_SCL,
    input  logic        iSIIC_SDA
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, STA, BYTE, ACK, RSTA, STO} state_t;

    state_t        state, state_n;
    logic [1:0]    qtr, qtr_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn, bitn_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    tx, tx_n;
    logic [7:0]    rx;
    logic          smp;
    logic [6:0]    slave_q;
    logic          rw_q, a16_q;
    logic [15:0]   addr_q;
    logic [7:0]    wdat_q;
    logic          adv, tick, accept, done_n, set_nack, ld_rdat, scl_n, sda_n;

    // A released SCL held low by the slave freezes the quarter timer.
    assign adv  = !(!dSIIC_SCL && !iSIIC_SCL);
    assign tick = adv && (cnt == CW'(CLK_DIV - 1));

    // Byte index: 0 slave+W, 1 addr hi, 2 addr lo, 3 wdat or slave+R, 4 read data.
    always_comb begin
        state_n  = state;
        qtr_n    = qtr;
        bitn_n   = bitn;
        bidx_n   = bidx;
        tx_n     = tx;
        accept   = 1'b0;
        done_n   = 1'b0;
        set_nack = 1'b0;
        ld_rdat  = 1'b0;
        if (state == IDLE) begin
            if (START && !DONE) begin
                accept  = 1'b1;
                state_n = STA;
                qtr_n   = 2'd0;
            end
        end else if (tick) begin
            qtr_n = qtr + 2'd1;
            if (qtr == 2'd3) begin
                case (state)
                    STA, RSTA: begin
                        state_n = BYTE;
                        bitn_n  = 3'd0;
                        tx_n    = {slave_q, state == RSTA};
                        bidx_n  = (state == RSTA) ? 3'd3 : 3'd0;
                    end
                    BYTE: begin
                        if (bitn == 3'd7) begin
                            state_n = ACK;
                            ld_rdat = (bidx == 3'd4);
                        end else begin
                            bitn_n = bitn + 3'd1;
                            tx_n   = {tx[6:0], 1'b1};
                        end
                    end
                    ACK: begin
                        bitn_n = 3'd0;
                        if (bidx != 3'd4 && smp) begin
                            set_nack = 1'b1;
                            state_n  = STO;
                        end else begin
                            case (bidx)
                                3'd0: begin
                                    state_n = BYTE;
                                    bidx_n  = a16_q ? 3'd1 : 3'd2;
                                    tx_n    = a16_q ? addr_q[15:8] : addr_q[7:0];
                                end
                                3'd1: begin
                                    state_n = BYTE;
                                    bidx_n  = 3'd2;
                                    tx_n    = addr_q[7:0];
                                end
                                3'd2: begin
                                    if (rw_q) begin
                                        state_n = RSTA;
                                    end else begin
                                        state_n = BYTE;
                                        bidx_n  = 3'd3;
                                        tx_n    = wdat_q;
                                    end
                                end
                                3'd3: begin
                                    if (rw_q) begin
                                        state_n = BYTE;
                                        bidx_n  = 3'd4;
                                        tx_n    = 8'hFF;
                                    end else begin
                                        state_n = STO;
                                    end
                                end
                                default: state_n = STO;
                            endcase
                        end
                    end
                    STO: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Pad enables are derived from the next state so the registered pads line up with it.
    always_comb begin
        scl_n = 1'b0;
        sda_n = 1'b0;
        case (state_n)
            STA, RSTA: begin
                scl_n = (qtr_n == 2'd3);
                sda_n = qtr_n[1];
            end
            BYTE: begin
                scl_n = !qtr_n[1];
                sda_n = !tx_n[7];
            end
            ACK:  scl_n = !qtr_n[1];
            STO: begin
                scl_n = (qtr_n == 2'd0);
                sda_n = !qtr_n[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCK) begin
        if (RST) begin
            state     <= IDLE;
            qtr       <= '0;
            cnt       <= '0;
            bitn      <= '0;
            bidx      <= '0;
            tx        <= '1;
            rx        <= '0;
            smp       <= 1'b0;
            slave_q   <= '0;
            rw_q      <= 1'b0;
            a16_q     <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            NACK      <= 1'b0;
            RDAT      <= '0;
            dSIIC_SCL <= 1'b0;
            dSIIC_SDA <= 1'b0;
        end else begin
            state     <= state_n;
            qtr       <= qtr_n;
            bitn      <= bitn_n;
            bidx      <= bidx_n;
            tx        <= tx_n;
            DONE      <= done_n;
            dSIIC_SCL <= scl_n;
            dSIIC_SDA <= sda_n;
            if (state == IDLE)
                cnt <= '0;
            else if (adv)
                cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && qtr == 2'd2) begin
                if (state == ACK)  smp <= iSIIC_SDA;
                if (state == BYTE) rx  <= {rx[6:0], iSIIC_SDA};
            end
            if (accept) begin
                slave_q <= SLAVE;
                rw_q    <= RW;
                a16_q   <= ADDR16;
                addr_q  <= REG_ADDR;
                wdat_q  <= WDAT;
                BUSY    <= 1'b1;
                NACK    <= 1'b0;
            end
            if (done_n)   BUSY <= 1'b0;
            if (set_nack) NACK <= 1'b1;
            if (ld_rdat)  RDAT <= rx;
        end
    end
endmodule
